// File: rtl/ring_osc_trim_ctrl.sv
// ring_osc_trim_ctrl: closed-loop trim calibration for the 13-stage ring oscillator
// Ports: clock/reset (async, active-high); enable runs calibration; init_step, target, tol configure it;
// osc_div is the raw divided oscillator; trim/osc_reset drive the oscillator; trim_step, meas_count,
// busy, locked, fail report status. Define RING_OSC_TRIM_TRACK_EN to keep tracking after lock.
module ring_osc_trim_ctrl #(
  parameter int CNT_W = 12,
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_ITER = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [4:0]       init_step,
  input  logic [CNT_W-1:0] target,
  input  logic [CNT_W-1:0] tol,
  input  logic             osc_div,
  output logic [25:0]      trim,
  output logic             osc_reset,
  output logic [4:0]       trim_step,
  output logic [CNT_W-1:0] meas_count,
  output logic             busy,
  output logic             locked,
  output logic             fail
);
  localparam int TW = $clog2(WINDOW_CYCLES + SETTLE_CYCLES + RESET_CYCLES + 1);
  localparam int IW = $clog2(MAX_ITER + 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_SETTLE, S_MEASURE, S_ADJUST, S_LOCKED, S_FAIL} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [4:0] step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat, meas_d, lo;
  logic [CNT_W:0] hi;
  logic [2:0] sync;
  logic locked_d, fail_d, trk_q, trk_d, rise, too_fast, too_slow;
  // sync[1:0] is the synchronizer, sync[2] the edge-detect flop
  assign rise = sync[1] & ~sync[2];
  assign cnt_sat = &cnt_q ? cnt_q : cnt_q + CNT_W'(rise);
  assign hi = {1'b0, target} + {1'b0, tol};
  assign lo = tol > target ? '0 : target - tol;
  assign too_fast = {1'b0, meas_count} > hi;
  assign too_slow = meas_count < lo;
  assign osc_reset = state_q == S_IDLE || state_q == S_START;
  assign busy = !trk_q && (state_q == S_START || state_q == S_SETTLE || state_q == S_MEASURE || state_q == S_ADJUST);
  always_comb begin
    state_d = state_q;
    tcnt_d = tcnt_q + TW'(1);
    iter_d = iter_q;
    step_d = trim_step;
    cnt_d = '0;
    meas_d = meas_count;
    locked_d = locked;
    fail_d = fail;
    trk_d = trk_q;
    if (!enable) begin
      state_d = S_IDLE;
      trk_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_START;
          tcnt_d = '0;
          step_d = init_step > 5'd26 ? 5'd26 : init_step;
          iter_d = '0;
          locked_d = 1'b0;
          fail_d = 1'b0;
        end
        S_START: if (tcnt_q == TW'(RESET_CYCLES - 1)) begin
          state_d = S_SETTLE;
          tcnt_d = '0;
        end
        S_SETTLE: if (tcnt_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = S_MEASURE;
          tcnt_d = '0;
        end
        S_MEASURE: begin
          cnt_d = cnt_sat;
          if (tcnt_q == TW'(WINDOW_CYCLES - 1)) begin
            meas_d = cnt_sat;
            state_d = S_ADJUST;
          end
        end
        S_ADJUST: begin
          tcnt_d = '0;
          if (!too_fast && !too_slow) begin
            state_d = S_LOCKED;
            locked_d = 1'b1;
          end else if (too_fast ? trim_step == 5'd26 : trim_step == 5'd0) begin
            state_d = S_FAIL;
            locked_d = 1'b0;
            fail_d = 1'b1;
            trk_d = 1'b0;
          end else begin
            step_d = too_fast ? trim_step + 5'd1 : trim_step - 5'd1;
            locked_d = 1'b0;
            state_d = S_SETTLE;
            if (!trk_q) begin
              iter_d = iter_q + IW'(1);
              // the adjustment is applied, but hitting the limit ends the calibration
              state_d = iter_d == IW'(MAX_ITER) ? S_FAIL : S_SETTLE;
              fail_d = iter_d == IW'(MAX_ITER);
            end
          end
        end
`ifdef RING_OSC_TRIM_TRACK_EN
        S_LOCKED: begin
          state_d = S_SETTLE;
          tcnt_d = '0;
          trk_d = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tcnt_q <= '0;
      iter_q <= '0;
      trim_step <= '0;
      trim <= '0;
      cnt_q <= '0;
      meas_count <= '0;
      locked <= 1'b0;
      fail <= 1'b0;
      trk_q <= 1'b0;
      sync <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      iter_q <= iter_d;
      trim_step <= step_d;
      // thermometer fill: step k sets the low k bits, primaries first then secondaries
      trim <= 26'((27'd1 << step_d) - 27'd1);
      cnt_q <= cnt_d;
      meas_count <= meas_d;
      locked <= locked_d;
      fail <= fail_d;
      trk_q <= trk_d;
      sync <= {sync[1:0], osc_div};
    end
  end
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// tb_ring_osc_trim_ctrl: directed bench with a trim-dependent oscillator edge model
module tb_ring_osc_trim_ctrl;
  localparam int W = 1408;
  logic clock = 1'b0;
  logic reset, enable, osc_div, osc_reset, busy, locked, fail;
  logic [4:0] init_step, trim_step;
  logic [11:0] target, tol, meas_count;
  logic [25:0] trim;
  int n_cmp = 0, n_bad = 0;
  int mode = 2;
  int ph = 1 << 20;
  logic [25:0] trim_q = '0;
  logic rst_q = 1'b1;
  typedef struct {
    int st, tg, tl, md;
    logic lk, fl;
    int step;
    logic [25:0] tr;
    int meas;
  } vec_t;
  vec_t tbl [8];

  ring_osc_trim_ctrl #(.WINDOW_CYCLES(W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .init_step(init_step),
    .target(target), .tol(tol), .osc_div(osc_div), .trim(trim),
    .osc_reset(osc_reset), .trim_step(trim_step), .meas_count(meas_count),
    .busy(busy), .locked(locked), .fail(fail)
  );

  always #5 clock = ~clock;

  function automatic int edges(input int s);
    return mode == 0 ? 600 - 15 * s : mode == 1 ? 700 : 0;
  endfunction

  // oscillator model: after each release or trim change, emit a burst of edges landing in the window
  always @(negedge clock) begin
    if (!osc_reset && (rst_q || trim != trim_q)) ph = 0;
    else if (ph < (1 << 20)) ph++;
    trim_q = trim;
    rst_q = osc_reset;
    osc_div = ph >= 20 && ph < 20 + 2 * edges($countones(trim)) && ph % 2 == 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int st, input int tg, input int tl, input int md, input int budget);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    init_step = 5'(st);
    target = 12'(tg);
    tol = 12'(tl);
    mode = md;
    enable = 1'b1;
    @(negedge clock);
    for (int i = 0; i < budget && !(locked || fail); i++) @(negedge clock);
    if (!(locked || fail)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no locked/fail expected done within %0d cycles", budget);
    end
  endtask

  initial begin
    tbl[0] = '{14, 3, 10, 2, 1'b1, 1'b0, 14, 26'h0003FFF, 0};
    tbl[1] = '{31, 0, 0, 2, 1'b1, 1'b0, 26, 26'h3FFFFFF, 0};
    tbl[2] = '{26, 100, 5, 1, 1'b0, 1'b1, 26, 26'h3FFFFFF, 700};
    tbl[3] = '{0, 5, 2, 2, 1'b0, 1'b1, 0, 26'h0000000, 0};
    tbl[4] = '{13, 405, 0, 0, 1'b1, 1'b0, 13, 26'h0001FFF, 405};
    tbl[5] = '{13, 4095, 4095, 1, 1'b1, 1'b0, 13, 26'h0001FFF, 700};
    tbl[6] = '{1, 580, 5, 0, 1'b1, 1'b0, 1, 26'h0000001, 585};
    tbl[7] = '{2, 575, 5, 0, 1'b1, 1'b0, 2, 26'h0000003, 570};
    reset = 1'b1;
    enable = 1'b0;
    init_step = '0;
    target = '0;
    tol = '0;
    repeat (3) @(negedge clock);
    chk("rst_trim", 32'(trim), 0);
    chk("rst_osc_reset", 32'(osc_reset), 1);
    chk("rst_step", 32'(trim_step), 0);
    chk("rst_meas", 32'(meas_count), 0);
    chk("rst_flags", {busy, locked, fail}, 0);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].st, tbl[i].tg, tbl[i].tl, tbl[i].md, 3000);
      chk($sformatf("v%0d_locked", i), 32'(locked), 32'(tbl[i].lk));
      chk($sformatf("v%0d_fail", i), 32'(fail), 32'(tbl[i].fl));
      chk($sformatf("v%0d_step", i), 32'(trim_step), 32'(tbl[i].step));
      chk($sformatf("v%0d_trim", i), 32'(trim), 32'(tbl[i].tr));
      chk($sformatf("v%0d_meas", i), 32'(meas_count), 32'(tbl[i].meas));
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_osc_reset", i), 32'(osc_reset), 0);
    end
    run(0, 450, 10, 0, 20000);
    chk("up_locked", {locked, fail}, 2'b10);
    chk("up_step", 32'(trim_step), 10);
    chk("up_meas", 32'(meas_count), 450);
    chk("up_trim", 32'(trim), 32'h3FF);
    run(20, 450, 10, 0, 20000);
    chk("dn_locked", {locked, fail}, 2'b10);
    chk("dn_step", 32'(trim_step), 10);
    chk("dn_trim", 32'(trim), 32'h3FF);
    enable = 1'b0;
    @(negedge clock);
    chk("idle_hold", {locked, osc_reset, busy}, 3'b110);
    chk("idle_step", 32'(trim_step), 10);
    init_step = 5'd5;
    enable = 1'b1;
    @(negedge clock);
    chk("restart_flags", {locked, fail, osc_reset, busy}, 4'b0011);
    chk("restart_step", 32'(trim_step), 5);
    chk("restart_trim", 32'(trim), 32'h1F);
    repeat (7) @(negedge clock);
    chk("settle_flags", {osc_reset, busy}, 2'b01);
    enable = 1'b0;
    @(negedge clock);
    chk("drop_flags", {osc_reset, busy}, 2'b10);
    chk("drop_step", 32'(trim_step), 5);
    run(10, 450, 10, 0, 4000);
    chk("reen_locked", {locked, fail}, 2'b10);
    chk("reen_step", 32'(trim_step), 10);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    init_step = 5'd3;
    enable = 1'b1;
    repeat (200) @(negedge clock);
    chk("meas_busy", {osc_reset, busy}, 2'b01);
    #2 reset = 1'b1;
    #1;
    chk("amid_trim", 32'(trim), 0);
    chk("amid_flags", {osc_reset, busy, locked, fail}, 4'b1000);
    chk("amid_meas", 32'(meas_count), 0);
    chk("amid_step", 32'(trim_step), 0);
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    run(20, 100, 5, 1, 15000);
    chk("sat_flags", {locked, fail, busy}, 3'b010);
    chk("sat_step", 32'(trim_step), 26);
    chk("sat_trim", 32'(trim), 32'h3FFFFFF);
    chk("sat_meas", 32'(meas_count), 700);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ring_osc_trim_ctrl.md
Name: ring_osc_trim_ctrl

Overview:
Closed-loop trim calibration controller for the 13-stage tunable ring oscillator (26-bit trim, 2 bits per stage).
- Counts rising edges of a divided oscillator output over a fixed window of reference-clock cycles.
- Compares the count against a programmed target and steps the trim up or down until the count is inside a tolerance band.
- Sits beside the oscillator in the clocking block and is configured from housekeeping registers.

Parameters:
- CNT_W, 12: width of the edge counter, target and tolerance.
- WINDOW_CYCLES, 256: reference clock cycles per measurement window.
- SETTLE_CYCLES, 16: wait after each trim change or oscillator release before measuring (at least 4).
- RESET_CYCLES, 4: cycles osc_reset is held when a calibration starts.
- MAX_ITER, 32: maximum trim adjustments before declaring failure.

Ports:
- clock  in  1  reference clock.
- reset  in  1  asynchronous active-high reset.
- enable  in  1  level; 1 runs calibration, 0 returns to IDLE.
- init_step  in  5  starting trim step, 0..26; values >26 are clamped to 26.
- target  in  CNT_W  desired edge count per window.
- tol  in  CNT_W  allowed absolute deviation from target.
- osc_div  in  1  divided oscillator output, asynchronous to clock.
- trim  out  26  trim vector to the oscillator.
- osc_reset  out  1  oscillator reset/stop.
- trim_step  out  5  current step, 0..26.
- meas_count  out  CNT_W  last completed window count.
- busy  out  1  calibration in progress.
- locked  out  1  count within band.
- fail  out  1  calibration failed.

Behaviour:
Reset values:
- trim = 0, trim_step = 0, meas_count = 0.
- osc_reset = 1.
- busy = locked = fail = 0.

Trim encoding (registered, derived from trim_step):
- Primary bits fill first: trim[k-1:0] = 1 for k ≤ 13.
- Secondary bits fill next: for k > 13, trim[12:0] = all ones and trim[13+(k-13)-1:13] = 1.
- Step 0 is the fastest setting, step 26 the slowest.
- trim updates in the same cycle as trim_step.

osc_div handling:
- osc_div passes through a 2-flop synchronizer plus an edge-detect flop.
- One edge is counted per synchronized 0→1 transition.
- Pipeline latency is 3 cycles.
- The counter saturates at all-ones.

Band comparison:
- hi = target + tol, computed in CNT_W+1 bits with no wrap.
- lo = target − tol, clamped to 0 when tol > target.

FSM:
- IDLE: osc_reset = 1, busy = 0. locked and fail hold their last values. On enable = 1: trim_step ← clamp(init_step), clear locked, fail and the iteration count, go to START.
- START: osc_reset = 1 for RESET_CYCLES, busy = 1, then go to SETTLE.
- SETTLE: osc_reset = 0. Wait SETTLE_CYCLES with the edge counter cleared, then go to MEASURE.
- MEASURE: count edges for exactly WINDOW_CYCLES. On the final cycle, latch meas_count and go to ADJUST.
- ADJUST (1 cycle):
  - count > hi (too fast): if step < 26, step+1 → SETTLE; if step = 26 → FAIL.
  - count < lo (too slow): if step > 0, step−1 → SETTLE; if step = 0 → FAIL.
  - otherwise → LOCKED.
  - Each step change increments the iteration count. Reaching MAX_ITER → FAIL instead of SETTLE.
- LOCKED: locked = 1, busy = 0, trim held, oscillator running.
- FAIL: fail = 1, busy = 0, locked = 0, trim held, oscillator running.
- Any state with enable = 0 → IDLE next cycle. trim_step is retained.
- Re-asserting enable restarts from init_step.
- target and tol are sampled only in ADJUST.
- Asynchronous reset in any state forces all reset values immediately.

Optional Feature:
Macro: RING_OSC_TRIM_TRACK_EN
- Defined:
  - LOCKED runs back-to-back SETTLE/MEASURE windows (busy stays 0).
  - Out-of-band results adjust the step by ±1; locked drops for that window.
  - In tracking, the iteration limit is not applied.
  - A step bound violation goes to FAIL.
- Undefined: LOCKED is terminal and static until enable drops.

Test Plan:
- Apply reset mid-MEASURE → next sample shows trim = 0, osc_reset = 1, busy = 0, meas_count = 0.
- Bench oscillator model giving 600 − 15·step edges/window; target = 450, tol = 10, init_step = 0 → step increments to 10, meas_count = 450, locked = 1, trim = 26'h00003FF.
- Same model with init_step = 20 → step decrements to 10, locked = 1. Step 14 gives trim = 26'h0003FFF | (1<<13).
- Model at a constant 700 edges with target = 100, tol = 5 → step climbs to 26, fail = 1, trim = 26'h3FFFFFF.
- target = 3, tol = 10 with the model at 0 edges → lo clamps to 0, locked at init_step with no adjustment.
- enable dropped mid-SETTLE → IDLE within 1 cycle, osc_reset = 1, trim_step retained. Re-enable restarts from init_step with locked = 0.
